// File: rtl/npu_pkg.sv
// Shared NPU types: activation select codes and default table sizing.
`timescale 1ns/1ps
package npu_pkg;

  localparam int LUT_AW_DEFAULT = 8;

  // Codes 8..15 are unassigned and behave as ACT_NONE in the datapath.
  typedef enum logic [3:0] {
    ACT_NONE    = 4'd0,
    ACT_RELU    = 4'd1,
    ACT_RELU6   = 4'd2,
    ACT_SIGMOID = 4'd3,
    ACT_TANH    = 4'd4,
    ACT_SWISH   = 4'd5,
    ACT_GELU    = 4'd6,
    ACT_LEAKY   = 4'd7
  } activation_t;

  // True for the modes whose result comes from the lookup table.
  function automatic logic act_uses_lut(input activation_t act);
    return (act == ACT_SIGMOID) || (act == ACT_TANH) ||
           (act == ACT_SWISH)   || (act == ACT_GELU);
  endfunction

endpackage

// File: rtl/act_lane.sv
// One lane of the activation datapath: pure combinational op select plus
// LUT index generation. The LUT itself lives in the parent.
`timescale 1ns/1ps
module act_lane
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LUT_AW     = LUT_AW_DEFAULT
) (
  input  activation_t                   act,
  input  logic signed [DATA_WIDTH-1:0]  x,
  input  logic signed [DATA_WIDTH-1:0]  clip_max,
  input  logic        [2:0]             leak_shift,
  output logic        [LUT_AW-1:0]      lut_idx,
  input  logic        [DATA_WIDTH-1:0]  lut_rdata,
  output logic signed [DATA_WIDTH-1:0]  y,
  output logic                          clipped
);

  logic signed [DATA_WIDTH-1:0] relu_v;
  logic signed [DATA_WIDTH-1:0] leaky_v;

  // Offset-binary table index: top bits of x with the sign bit flipped so
  // the most negative input lands on entry 0.
  always_comb begin
    lut_idx = x[DATA_WIDTH-1 -: LUT_AW];
    lut_idx[LUT_AW-1] = ~x[DATA_WIDTH-1];
  end

  // Select the lane result; all candidates fit in DATA_WIDTH so no overflow.
  always_comb begin
    relu_v  = x[DATA_WIDTH-1] ? '0 : x;
    leaky_v = x >>> leak_shift;
    y       = x;
    clipped = 1'b0;
    case (act)
      ACT_NONE: y = x;
      ACT_RELU: y = relu_v;
      ACT_RELU6: begin
        y       = (relu_v > clip_max) ? clip_max : relu_v;
        clipped = (x > clip_max);
      end
      ACT_LEAKY: y = x[DATA_WIDTH-1] ? leaky_v : x;
      ACT_SIGMOID, ACT_TANH, ACT_SWISH, ACT_GELU: y = lut_rdata;
      default: y = x;
    endcase
  end

endmodule

// File: rtl/activation_vec_pipe.sv
// Vector activation unit: LANES parallel lanes, two register stages
// (S1 = lane result incl. LUT read, S2 = output register) with
// valid/ready flow control and a saturating ReLU6 clip counter.
`timescale 1ns/1ps
module activation_vec_pipe
  import npu_pkg::*;
#(
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LUT_AW     = LUT_AW_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  activation_t                   in_act,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic signed [DATA_WIDTH-1:0]  clip_max,
  input  logic [2:0]                    leak_shift,
  input  logic                          lut_we,
  input  logic [LUT_AW-1:0]             lut_addr,
  input  logic [DATA_WIDTH-1:0]         lut_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [15:0]                   sat_count
);

  localparam int LUT_DEPTH = 1 << LUT_AW;
  localparam int VW        = LANES * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] lut_mem [LUT_DEPTH];

  logic            ready_en;
  logic            s1_valid;
  logic [VW-1:0]   s1_data;
  logic            s2_valid;
  logic            advance;
  logic            in_fire;
  logic [VW-1:0]   lane_y;
  logic [LANES-1:0] lane_clip;
  logic [15:0]     clip_cnt;
  logic [16:0]     sat_sum;

  assign advance   = !s2_valid || out_ready;
  // ready_en keeps in_ready low through reset and until the first clock after.
  assign in_ready  = ready_en && (!s1_valid || advance);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Each lane gets its own read port into the shared table contents.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LUT_AW-1:0]            idx;
    logic signed [DATA_WIDTH-1:0] y;

    act_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LUT_AW     (LUT_AW)
    ) u_lane (
      .act        (in_act),
      .x          (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .clip_max   (clip_max),
      .leak_shift (leak_shift),
      .lut_idx    (idx),
      .lut_rdata  (lut_mem[idx]),
      .y          (y),
      .clipped    (lane_clip[g])
    );

    assign lane_y[g*DATA_WIDTH +: DATA_WIDTH] = y;
  end

  // Number of lanes clipped in the current input beat, and the unsaturated sum.
  always_comb begin
    clip_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      clip_cnt = clip_cnt + 16'(lane_clip[i]);
    end
    sat_sum = {1'b0, sat_count} + {1'b0, clip_cnt};
  end

  // Enable input acceptance one clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // S1: capture lane results (LUT read sees pre-write contents this cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= lane_y;
      end
    end
  end

  // S2: output register, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s1_data;
      end
    end
  end

  // Saturating count of ReLU6-clipped lanes, updated on each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (in_fire) begin
      sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  // Table write port; contents survive reset and are undefined until loaded.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut_mem[lut_addr] <= lut_wdata;
    end
  end

endmodule

// File: doc/activation_vec_pipe.md
ACTIVATION_VEC_PIPE -- requirements
Module: activation_vec_pipe

Interface
- REQ-001 SHALL have parameter LANES, default 8: number of parallel activation lanes.
- REQ-002 SHALL have parameter DATA_WIDTH, default 8: signed element width per lane, minimum 4.
- REQ-003 SHALL have parameter LUT_AW, default 8: LUT address width, with LUT_AW <= DATA_WIDTH and 2**LUT_AW entries.
- REQ-004 SHALL have port clk, input, 1: clock; all logic is rising-edge.
- REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-006 SHALL have port in_valid, input, 1: input beat valid.
- REQ-007 SHALL have port in_ready, output, 1: block accepts a beat.
- REQ-008 SHALL have port in_act, input, activation_t: per-beat activation select.
- REQ-009 SHALL have port in_data, input, LANES*DATA_WIDTH: lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH], signed.
- REQ-010 SHALL have port clip_max, input, DATA_WIDTH: ReLU6 upper bound, signed, quasi-static.
- REQ-011 SHALL have port leak_shift, input, 3: LeakyReLU right-shift for negative inputs, quasi-static.
- REQ-012 SHALL have port lut_we, input, 1: LUT write strobe.
- REQ-013 SHALL have port lut_addr, input, LUT_AW: LUT write address.
- REQ-014 SHALL have port lut_wdata, input, DATA_WIDTH: LUT write data.
- REQ-015 SHALL have port out_valid, output, 1: output beat valid.
- REQ-016 SHALL have port out_ready, input, 1: downstream accepts.
- REQ-017 SHALL have port out_data, output, LANES*DATA_WIDTH: result, same lane packing as in_data.
- REQ-018 SHALL have port sat_count, output, 16: count of lanes clipped by ReLU6.

Function
- REQ-019 SHALL be a 2-stage pipeline: S1 registers the per-lane operation result and LUT read; S2 is the output register.
- REQ-020 SHALL transfer on the in_valid&&in_ready and out_valid&&out_ready handshakes, with the pipeline advancing when advance = !s2_valid || out_ready.
- REQ-021 SHALL drive in_ready = !s1_valid || advance, so that a bubble in S1 is absorbed while out_ready is low.
- REQ-022 SHALL make out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- REQ-023 SHALL give a latency of exactly 2 cycles from an accepted beat to out_valid with no stall, and sustain a throughput of 1 beat/cycle.
- REQ-024 SHALL carry in_act with each beat, so that mode changes between consecutive beats take effect per beat.
- REQ-025 SHALL give ACT_NONE: y = x.
- REQ-026 SHALL give ACT_RELU: y = max(0, x).
- REQ-027 SHALL give ACT_RELU6: y = min(max(0, x), clip_max), and increment sat_count once per lane where x > clip_max on the S1 accept.
- REQ-028 SHALL give LeakyReLU (the activation_t value ACT_LEAKY): y = x for x >= 0, and y = x >>> leak_shift otherwise (arithmetic shift).
- REQ-029 SHALL give ACT_SIGMOID, ACT_TANH, ACT_SWISH and ACT_GELU: y = LUT[idx], where idx = top LUT_AW bits of x with the MSB inverted (offset binary, so the most negative x maps to 0).
- REQ-030 SHALL treat undefined act codes as ACT_NONE.
- REQ-031 SHALL write LUT[lut_addr] = lut_wdata on a rising edge with lut_we=1, with writes allowed while data is in flight.
- REQ-032 SHALL make an S1 read of the address being written in the same cycle return the old value (read-before-write).
- REQ-033 SHALL saturate sat_count at 16'hFFFF, with no wrap.
- REQ-034 SHALL add up to LANES to sat_count per cycle.
- REQ-035 SHALL compute each lane's result at full width, so that no intermediate overflow occurs.

Reset
- REQ-036 SHALL, while rst_n=0, drive out_valid=0, internal s1_valid=0, out_data=0, sat_count=0 and in_ready=0.
- REQ-037 SHALL drive in_ready=1 from the first clock after release.
- REQ-038 SHALL NOT reset the LUT contents; the LUT is undefined until written.
- REQ-039 SHALL discard in-flight beats on a reset mid-stream, with no output produced for them.

Structure
- REQ-040 SHALL use activation_t from npu_pkg, with ACT_LEAKY added to npu_pkg.
- REQ-041 SHALL define LUT_AW_DEFAULT in npu_pkg.
- REQ-042 SHALL implement the per-lane combinational datapath as sub-module act_lane, instantiated LANES times.
- REQ-043 SHALL share one LUT read port per lane, with the array replicated or multiported at implementation choice.

Verification
- REQ-044 SHALL cover directed scenario: LANES=8, ACT_RELU, lanes {-128,-1,0,1,5,6,7,127}, out_ready=1 -> out {0,0,0,1,5,6,7,127} exactly 2 cycles later.
- REQ-045 SHALL cover directed scenario: ACT_RELU6 with clip_max=6, the same input -> {0,0,0,1,5,6,6,6}, with sat_count=2.
- REQ-046 SHALL cover directed scenario: leak_shift=2 with ACT_LEAKY, x=-128 -> -32, and x=-1 -> -1.
- REQ-047 SHALL cover directed scenario: LUT[i]=i^8'h55 loaded, ACT_SIGMOID with x=-128 -> 8'h55, and x=0 -> LUT[128]=8'hD5; also a same-cycle write to 128 while x=0 is in S1 -> the old value is returned.
- REQ-048 SHALL cover directed scenario: a back-to-back stream with out_ready low for 3 cycles -> in_ready drops after 2 beats are buffered, out_data is stable, and there is no loss or duplication.
- REQ-049 SHALL cover directed scenario: rst_n asserted with 2 beats in flight -> out_valid=0 immediately, sat_count=0, and a new beat after release has latency 2.
